// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/MEM pipeline stages, the arbiter and the memory macro.
// slave = arbiter view; master = pipeline + memory side (testbench / parent).
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   localparam int BW = DW / 8;

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_flush;
   logic          if_done;
   logic [DW-1:0] if_rdata;
   logic          if_stall;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [BW-1:0] d_be;
   logic          d_done;
   logic [DW-1:0] d_rdata;
   logic          d_stall;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [BW-1:0] mem_be;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, if_flush,
      output if_done, if_rdata, if_stall,
      input  d_req, d_we, d_addr, d_wdata, d_be,
      output d_done, d_rdata, d_stall,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr, if_flush,
      input  if_done, if_rdata, if_stall,
      output d_req, d_we, d_addr, d_wdata, d_be,
      input  d_done, d_rdata, d_stall,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between IF fetches and MEM-stage loads/stores.
// Latency: grant + issue in cycle 0, done pulse with data in cycle LATENCY, next grant in LATENCY+1.
// Backpressure: one access in flight; requesters stall until their done pulse, data side has priority.
module mem_port_arbiter #(
   parameter int LATENCY = 2,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input logic              clk,
   input logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam int BW = DW / 8;
   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   typedef enum logic {OWN_IF, OWN_D} owner_t;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
   } mem_cmd_t;

   state_t        state_q, state_nxt;
   owner_t        owner_q, owner_nxt;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic          discard_q, discard_nxt;
   mem_cmd_t      cmd_q, cmd_nxt;

   logic          grant_d, grant_if, grant;
   mem_cmd_t      grant_cmd;
   logic          in_done, if_done, d_done;

   // No grant can happen in a reset cycle, so gating the requests covers it.
   assign grant_d  = ~reset & bus.d_req;
   assign grant_if = ~reset & ~bus.d_req & bus.if_req & ~bus.if_flush;

   always_comb begin
      state_nxt   = state_q;
      owner_nxt   = owner_q;
      cnt_nxt     = cnt_q;
      discard_nxt = discard_q;
      cmd_nxt     = cmd_q;
      grant       = 1'b0;
      grant_cmd   = '0;

      case (state_q)
         IDLE: begin
            if (grant_d || grant_if) begin
               grant = 1'b1;
               if (grant_d) begin
                  owner_nxt       = OWN_D;
                  grant_cmd.we    = bus.d_we;
                  grant_cmd.addr  = bus.d_addr;
                  grant_cmd.wdata = bus.d_wdata;
                  grant_cmd.be    = bus.d_we ? bus.d_be : {BW{1'b1}};
               end else begin
                  owner_nxt       = OWN_IF;
                  grant_cmd.we    = 1'b0;
                  grant_cmd.addr  = bus.if_addr;
                  grant_cmd.wdata = '0;
                  grant_cmd.be    = {BW{1'b1}};
               end
               cmd_nxt   = grant_cmd;
               cnt_nxt   = CW'(LATENCY - 1);
               state_nxt = (LATENCY == 1) ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (owner_q == OWN_IF && bus.if_flush)
               discard_nxt = 1'b1;
            // Counter parks at 1 rather than wrapping; it is only reloaded at grant.
            if (cnt_q == CW'(1))
               state_nxt = DONE;
            else
               cnt_nxt = cnt_q - CW'(1);
         end
         DONE: begin
            state_nxt   = IDLE;
            discard_nxt = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= OWN_IF;
         cnt_q     <= '0;
         discard_q <= 1'b0;
         cmd_q     <= '0;
      end else begin
         state_q   <= state_nxt;
         owner_q   <= owner_nxt;
         cnt_q     <= cnt_nxt;
         discard_q <= discard_nxt;
         cmd_q     <= cmd_nxt;
      end
   end

   // A flush landing in the data cycle itself must also kill the fetch result.
   assign in_done = ~reset & (state_q == DONE);
   assign if_done = in_done & (owner_q == OWN_IF) & ~discard_q & ~bus.if_flush;
   assign d_done  = in_done & (owner_q == OWN_D);

   assign bus.mem_en    = grant;
   assign bus.mem_we    = grant & grant_cmd.we;
   assign bus.mem_addr  = reset ? '0 : (grant ? grant_cmd.addr  : cmd_q.addr);
   assign bus.mem_wdata = reset ? '0 : (grant ? grant_cmd.wdata : cmd_q.wdata);
   assign bus.mem_be    = reset ? '0 : (grant ? grant_cmd.be    : cmd_q.be);

   assign bus.if_done  = if_done;
   assign bus.if_rdata = if_done ? bus.mem_rdata : '0;
   assign bus.if_stall = bus.if_req & ~if_done;

   assign bus.d_done  = d_done;
   assign bus.d_rdata = d_done ? bus.mem_rdata : '0;
   assign bus.d_stall = bus.d_req & ~d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle-by-cycle vectors for LATENCY=2 plus a back-to-back fetch sequence at LATENCY=1.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic r2  = 1'b1;
   logic r1  = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.AW(32), .DW(32)) b2 ();
   mem_port_arbiter_if #(.AW(32), .DW(32)) b1 ();

   mem_port_arbiter #(.LATENCY(2), .AW(32), .DW(32)) dut2 (.clk(clk), .reset(r2), .bus(b2));
   mem_port_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut1 (.clk(clk), .reset(r1), .bus(b1));

   // One-cycle memory for the LATENCY=1 instance; data is a tag of the address.
   logic [31:0] m1 = 32'h0;
   always @(posedge clk) if (b1.mem_en) m1 <= b1.mem_addr ^ 32'hA5A50000;
   assign b1.mem_rdata = m1;

   typedef struct {
      logic rst; logic ifq; logic [31:0] ia; logic ifl;
      logic dq; logic we; logic [31:0] da; logic [31:0] wd; logic [3:0] be; logic [31:0] mr;
      logic en; logic mwe; logic [31:0] ma; logic [3:0] mbe; logic [31:0] mwd;
      logic idn; logic [31:0] ird; logic ist;
      logic ddn; logic [31:0] drd; logic dst;
   } vec_t;

   vec_t tab[$];

   function automatic vec_t mk(
      input logic rst, input logic ifq, input logic [31:0] ia, input logic ifl,
      input logic dq, input logic we, input logic [31:0] da, input logic [31:0] wd,
      input logic [3:0] be, input logic [31:0] mr,
      input logic en, input logic mwe, input logic [31:0] ma, input logic [3:0] mbe,
      input logic [31:0] mwd,
      input logic idn, input logic [31:0] ird, input logic ist,
      input logic ddn, input logic [31:0] drd, input logic dst);
      vec_t v;
      v.rst = rst; v.ifq = ifq; v.ia = ia; v.ifl = ifl;
      v.dq = dq; v.we = we; v.da = da; v.wd = wd; v.be = be; v.mr = mr;
      v.en = en; v.mwe = mwe; v.ma = ma; v.mbe = mbe; v.mwd = mwd;
      v.idn = idn; v.ird = ird; v.ist = ist;
      v.ddn = ddn; v.drd = drd; v.dst = dst;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int t, gcyc, gprev;
      b2.if_req = 0; b2.if_addr = 0; b2.if_flush = 0;
      b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0; b2.d_be = 0; b2.mem_rdata = 0;
      b1.if_req = 0; b1.if_addr = 0; b1.if_flush = 0;
      b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0; b1.d_be = 0;
      gprev = 0;

      //              rst ifq ia      ifl dq we da        wd            be    mr            en mwe ma        mbe   mwd          idn ird           ist ddn drd           dst
      // reset: requests present but nothing granted, outputs zeroed
      tab.push_back(mk(1, 1, 'h100,  0,  0, 0, 0,        0,            0,    0,            0, 0,  0,        0,    0,           0,  0,            1,  0,  0,            0));
      tab.push_back(mk(1, 0, 0,      0,  1, 1, 'h5000,   'hFFFF,       'hF,  0,            0, 0,  0,        0,    0,           0,  0,            0,  0,  0,            1));
      // IF read 0x100
      tab.push_back(mk(0, 1, 'h100,  0,  0, 0, 0,        0,            0,    0,            1, 0,  'h100,    'hF,  0,           0,  0,            1,  0,  0,            0));
      tab.push_back(mk(0, 1, 'h100,  0,  0, 0, 0,        0,            0,    0,            0, 0,  0,        0,    0,           0,  0,            1,  0,  0,            0));
      tab.push_back(mk(0, 1, 'h100,  0,  0, 0, 0,        0,            0,    'h00500093,   0, 0,  0,        0,    0,           1,  'h00500093,   0,  0,  0,            0));
      // store 0x2000, granted in cycle 3 of the previous access (IDLE there)
      tab.push_back(mk(0, 0, 0,      0,  1, 1, 'h2000,   'hDEADBEEF,   'h3,  0,            1, 1,  'h2000,   'h3,  'hDEADBEEF,  0,  0,            0,  0,  0,            1));
      tab.push_back(mk(0, 0, 0,      0,  1, 1, 'h2000,   'hDEADBEEF,   'h3,  0,            0, 0,  0,        0,    0,           0,  0,            0,  0,  0,            1));
      tab.push_back(mk(0, 0, 0,      0,  1, 1, 'h2000,   'hDEADBEEF,   'h3,  'h12345678,   0, 0,  0,        0,    0,           0,  0,            0,  1,  0,            0));
      tab.push_back(mk(0, 0, 0,      0,  0, 0, 0,        0,            0,    0,            0, 0,  0,        0,    0,           0,  0,            0,  0,  0,            0));
      // simultaneous IF + load: D first, IF granted in cycle 3
      tab.push_back(mk(0, 1, 'h108,  0,  1, 0, 'h2004,   0,            'hF,  0,            1, 0,  'h2004,   'hF,  0,           0,  0,            1,  0,  0,            1));
      tab.push_back(mk(0, 1, 'h108,  0,  1, 0, 'h2004,   0,            'hF,  0,            0, 0,  0,        0,    0,           0,  0,            1,  0,  0,            1));
      tab.push_back(mk(0, 1, 'h108,  0,  1, 0, 'h2004,   0,            'hF,  'hCAFE0001,   0, 0,  0,        0,    0,           0,  0,            1,  1,  'hCAFE0001,   0));
      tab.push_back(mk(0, 1, 'h108,  0,  0, 0, 0,        0,            0,    0,            1, 0,  'h108,    'hF,  0,           0,  0,            1,  0,  0,            0));
      tab.push_back(mk(0, 1, 'h108,  0,  0, 0, 0,        0,            0,    0,            0, 0,  0,        0,    0,           0,  0,            1,  0,  0,            0));
      tab.push_back(mk(0, 1, 'h108,  0,  0, 0, 0,        0,            0,    'h00000013,   0, 0,  0,        0,    0,           1,  'h00000013,   0,  0,  0,            0));
      tab.push_back(mk(0, 0, 0,      0,  0, 0, 0,        0,            0,    0,            0, 0,  0,        0,    0,           0,  0,            0,  0,  0,            0));
      // IF 0x104 flushed in cycle 1: no done in cycle 2; redirect 0x200 granted cycle 3
      tab.push_back(mk(0, 1, 'h104,  0,  0, 0, 0,        0,            0,    0,            1, 0,  'h104,    'hF,  0,           0,  0,            1,  0,  0,            0));
      tab.push_back(mk(0, 0, 0,      1,  0, 0, 0,        0,            0,    0,            0, 0,  0,        0,    0,           0,  0,            0,  0,  0,            0));
      tab.push_back(mk(0, 1, 'h200,  0,  0, 0, 0,        0,            0,    'hDEAD0000,   0, 0,  0,        0,    0,           0,  0,            1,  0,  0,            0));
      tab.push_back(mk(0, 1, 'h200,  0,  0, 0, 0,        0,            0,    0,            1, 0,  'h200,    'hF,  0,           0,  0,            1,  0,  0,            0));
      tab.push_back(mk(0, 1, 'h200,  0,  0, 0, 0,        0,            0,    0,            0, 0,  0,        0,    0,           0,  0,            1,  0,  0,            0));
      tab.push_back(mk(0, 1, 'h200,  0,  0, 0, 0,        0,            0,    'h00000297,   0, 0,  0,        0,    0,           1,  'h00000297,   0,  0,  0,            0));
      tab.push_back(mk(0, 0, 0,      0,  0, 0, 0,        0,            0,    0,            0, 0,  0,        0,    0,           0,  0,            0,  0,  0,            0));
      // load 0x3000 hit by reset in cycle 1; fresh load granted in cycle 3
      tab.push_back(mk(0, 0, 0,      0,  1, 0, 'h3000,   0,            'hF,  0,            1, 0,  'h3000,   'hF,  0,           0,  0,            0,  0,  0,            1));
      tab.push_back(mk(1, 0, 0,      0,  1, 0, 'h3000,   0,            'hF,  0,            0, 0,  0,        0,    0,           0,  0,            0,  0,  0,            1));
      tab.push_back(mk(0, 0, 0,      0,  0, 0, 0,        0,            0,    'h00000BAD,   0, 0,  0,        0,    0,           0,  0,            0,  0,  0,            0));
      tab.push_back(mk(0, 0, 0,      0,  1, 0, 'h3004,   0,            'hF,  0,            1, 0,  'h3004,   'hF,  0,           0,  0,            0,  0,  0,            1));
      tab.push_back(mk(0, 0, 0,      0,  1, 0, 'h3004,   0,            'hF,  0,            0, 0,  0,        0,    0,           0,  0,            0,  0,  0,            1));
      tab.push_back(mk(0, 0, 0,      0,  1, 0, 'h3004,   0,            'hF,  'h11112222,   0, 0,  0,        0,    0,           0,  0,            0,  1,  'h11112222,   0));
      tab.push_back(mk(0, 0, 0,      0,  0, 0, 0,        0,            0,    0,            0, 0,  0,        0,    0,           0,  0,            0,  0,  0,            0));
      // flush in IDLE blocks the IF grant for that cycle only
      tab.push_back(mk(0, 1, 'h300,  1,  0, 0, 0,        0,            0,    0,            0, 0,  0,        0,    0,           0,  0,            1,  0,  0,            0));
      tab.push_back(mk(0, 1, 'h300,  0,  0, 0, 0,        0,            0,    0,            1, 0,  'h300,    'hF,  0,           0,  0,            1,  0,  0,            0));
      tab.push_back(mk(0, 1, 'h300,  0,  0, 0, 0,        0,            0,    0,            0, 0,  0,        0,    0,           0,  0,            1,  0,  0,            0));
      tab.push_back(mk(0, 1, 'h300,  0,  0, 0, 0,        0,            0,    'h00000077,   0, 0,  0,        0,    0,           1,  'h00000077,   0,  0,  0,            0));
      tab.push_back(mk(0, 0, 0,      0,  0, 0, 0,        0,            0,    0,            0, 0,  0,        0,    0,           0,  0,            0,  0,  0,            0));

      for (int i = 0; i < tab.size(); i++) begin
         @(negedge clk);
         r2 = tab[i].rst;
         b2.if_req = tab[i].ifq; b2.if_addr = tab[i].ia; b2.if_flush = tab[i].ifl;
         b2.d_req = tab[i].dq; b2.d_we = tab[i].we; b2.d_addr = tab[i].da;
         b2.d_wdata = tab[i].wd; b2.d_be = tab[i].be; b2.mem_rdata = tab[i].mr;
         #1;
         chk("mem_en",  i, 32'(b2.mem_en),   32'(tab[i].en));
         chk("if_done", i, 32'(b2.if_done),  32'(tab[i].idn));
         chk("if_stall",i, 32'(b2.if_stall), 32'(tab[i].ist));
         chk("d_done",  i, 32'(b2.d_done),   32'(tab[i].ddn));
         chk("d_stall", i, 32'(b2.d_stall),  32'(tab[i].dst));
         if (tab[i].en || tab[i].rst) begin
            chk("mem_we",   i, 32'(b2.mem_we), 32'(tab[i].mwe));
            chk("mem_addr", i, b2.mem_addr,    tab[i].ma);
         end
         if (tab[i].en) chk("mem_be", i, 32'(b2.mem_be), 32'(tab[i].mbe));
         if ((tab[i].en && tab[i].mwe) || tab[i].rst) chk("mem_wdata", i, b2.mem_wdata, tab[i].mwd);
         if (tab[i].idn) chk("if_rdata", i, b2.if_rdata, tab[i].ird);
         if (tab[i].ddn && !tab[i].we) chk("d_rdata", i, b2.d_rdata, tab[i].drd);
         if (tab[i].rst) begin
            chk("if_rdata_rst", i, b2.if_rdata, 32'h0);
            chk("d_rdata_rst",  i, b2.d_rdata,  32'h0);
         end
      end

      // LATENCY=1: back-to-back fetches, grant every 2 cycles, done 1 cycle after mem_en
      @(negedge clk);
      r1 = 1'b1; b1.if_req = 1'b1; b1.if_addr = 32'h400;
      #1;
      chk("l1_rst_en", 0, 32'(b1.mem_en), 32'h0);
      @(negedge clk);
      r1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         a = 32'h400 + 32'(4 * k);
         b1.if_addr = a;
         #1;
         t = 0;
         while (b1.mem_en !== 1'b1 && t < 4) begin
            @(negedge clk); #1; t++;
         end
         chk("l1_grant", k, 32'(b1.mem_en), 32'h1);
         chk("l1_addr",  k, b1.mem_addr, a);
         gcyc = cyc;
         if (k > 0) chk("l1_spacing", k, 32'(gcyc - gprev), 32'd2);
         gprev = gcyc;
         @(negedge clk); #1;
         chk("l1_done",  k, 32'(b1.if_done), 32'h1);
         chk("l1_rdata", k, b1.if_rdata, a ^ 32'hA5A50000);
         chk("l1_stall", k, 32'(b1.if_stall), 32'h0);
         chk("l1_noen",  k, 32'(b1.mem_en), 32'h0);
         @(negedge clk);
      end
      b1.if_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
